// File: rtl/noc_router_arb_mux_pkg.sv
// Shared NoC arbitration helpers: one-hot decode and circular first-one search.
package noc_router_arb_mux_pkg;

  localparam int MAX_INPUTS = 32;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  function automatic int onehot_to_idx(input logic [MAX_INPUTS-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_INPUTS; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

  // First set bit of req at or after index ptr, wrapping at n; one-hot result.
  function automatic logic [MAX_INPUTS-1:0] rr_first(input logic [MAX_INPUTS-1:0] req,
                                                     input int ptr, input int n);
    logic [MAX_INPUTS-1:0] g;
    logic [MAX_INPUTS-1:0] tmp;
    logic                  found;
    int                    j;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_INPUTS; i++) begin
      if (!found && i < n) begin
        j = ptr + i;
        if (j >= n) j = j - n;
        tmp = req >> j;
        if (tmp[0]) begin
          g     = MAX_INPUTS'(1) << j;
          found = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/noc_router_arb_mux_arb_rr.sv
// Round-robin select with a registered one-hot priority pointer.
module noc_router_arb_rr
  import noc_router_arb_mux_pkg::*;
#(
  parameter int INPUTS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INPUTS-1:0] req,
  input  logic              adv,
  input  logic [INPUTS-1:0] adv_oh,
  output logic [INPUTS-1:0] grant,
  output logic [INPUTS-1:0] ptr
);

  int ptr_idx;

  always_comb begin
    ptr_idx = onehot_to_idx(MAX_INPUTS'(ptr));
    grant   = INPUTS'(rr_first(MAX_INPUTS'(req), ptr_idx, INPUTS));
  end

  // Rotating the served one-hot left gives (g+1) mod INPUTS for any INPUTS.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ptr <= INPUTS'(1);
    end else if (adv) begin
      ptr <= {adv_oh[INPUTS-2:0], adv_oh[INPUTS-1]};
    end
  end

endmodule

// File: rtl/noc_router_arb_mux.sv
// Output merge stage: worm-locked round-robin arbitration feeding a one-entry register slice.
module noc_router_arb_mux
  import noc_router_arb_mux_pkg::*;
#(
  parameter int FLIT_WIDTH = 32,
  parameter int INPUTS     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [INPUTS*FLIT_WIDTH-1:0] in_flit,
  input  logic [INPUTS-1:0]            in_last,
  input  logic [INPUTS-1:0]            in_valid,
  output logic [INPUTS-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]        out_flit,
  output logic                         out_last,
  output logic                         out_valid,
  input  logic                         out_ready
);

  // Handshake: a flit moves on input i when in_valid[i] && in_ready[i]; on the
  // output when out_valid && out_ready. in_ready never looks at flit contents.

  arb_state_t              state;
  logic [INPUTS-1:0]       lock;
  logic [INPUTS-1:0]       grant;
  logic [INPUTS-1:0]       ptr;
  logic [INPUTS-1:0]       sel;
  logic [FLIT_WIDTH-1:0]   sel_flit;
  logic                    sel_last;
  logic                    accept;
  logic                    xfer;
  logic                    adv;

  noc_router_arb_rr #(.INPUTS(INPUTS)) u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (in_valid),
    .adv    (adv),
    .adv_oh (sel),
    .grant  (grant),
    .ptr    (ptr)
  );

  always_comb begin
    accept   = !out_valid || out_ready;
    sel      = (state == ST_LOCKED) ? lock : grant;
    in_ready = rst_n ? '0 : (sel & {INPUTS{accept}});
    xfer     = |(in_valid & in_ready);
    sel_last = |(in_last & sel);
    adv      = xfer && sel_last;
    sel_flit = '0;
    for (int i = 0; i < INPUTS; i++) begin
      sel_flit = sel_flit | (in_flit[i*FLIT_WIDTH +: FLIT_WIDTH] & {FLIT_WIDTH{sel[i]}});
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= ST_IDLE;
      lock      <= '0;
      out_valid <= 1'b0;
      out_flit  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (xfer) begin
        case (state)
          ST_IDLE: begin
            if (!sel_last) begin
              state <= ST_LOCKED;
              lock  <= sel;
            end
          end
          ST_LOCKED: begin
            if (sel_last) begin
              state <= ST_IDLE;
              lock  <= '0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
      if (accept) out_valid <= xfer;
      if (xfer) begin
        out_flit <= sel_flit;
        out_last <= sel_last;
      end
    end
  end

endmodule

// File: tb/tb_noc_router_arb_mux.sv
// Directed vector bench for noc_router_arb_mux (INPUTS = 2, FLIT_WIDTH = 32).
module tb_noc_router_arb_mux;

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  l;
    logic [31:0] f0;
    logic [31:0] f1;
    logic        ord;
    logic [1:0]  rdy;
    logic        ov;
    logic [31:0] of;
    logic        ol;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [63:0] in_flit = '0;
  logic [1:0]  in_last = '0;
  logic [1:0]  in_valid = '0;
  logic [1:0]  in_ready;
  logic [31:0] out_flit;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  vec_t tbl[15];

  noc_router_arb_mux #(.FLIT_WIDTH(32), .INPUTS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_flit   (in_flit),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [1:0] v, input logic [1:0] l, input logic [31:0] f0,
                              input logic [31:0] f1, input logic ord, input logic [1:0] rdy,
                              input logic ov, input logic [31:0] of, input logic ol);
    vec_t t;
    t.v = v; t.l = l; t.f0 = f0; t.f1 = f1; t.ord = ord;
    t.rdy = rdy; t.ov = ov; t.of = of; t.ol = ol;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check in_ready before the edge and the slice after it.
  task automatic step(input string name, input vec_t t);
    in_valid  = t.v;
    in_last   = t.l;
    in_flit   = {t.f1, t.f0};
    out_ready = t.ord;
    #1;
    chk({name, " in_ready"}, 32'(in_ready), 32'(t.rdy));
    @(posedge clk);
    #1;
    chk({name, " out_valid"}, 32'(out_valid), 32'(t.ov));
    chk({name, " out_flit"}, out_flit, t.of);
    chk({name, " out_last"}, 32'(out_last), 32'(t.ol));
  endtask

  initial begin
    //            v      l      f0     f1     ord   rdy    ov    of     ol
    tbl[0]  = mk(2'b10, 2'b00, 32'h0, 32'hA1, 1'b1, 2'b10, 1'b1, 32'hA1, 1'b0);
    tbl[1]  = mk(2'b10, 2'b00, 32'h0, 32'hA2, 1'b1, 2'b10, 1'b1, 32'hA2, 1'b0);
    tbl[2]  = mk(2'b10, 2'b10, 32'h0, 32'hA3, 1'b1, 2'b10, 1'b1, 32'hA3, 1'b1);
    tbl[3]  = mk(2'b00, 2'b00, 32'h0, 32'h0,  1'b1, 2'b00, 1'b0, 32'hA3, 1'b1);
    // pointer is back at input 0 after input 1's worm
    tbl[4]  = mk(2'b11, 2'b11, 32'hB0, 32'hB1, 1'b1, 2'b01, 1'b1, 32'hB0, 1'b1);
    // input 0 worm with a valid gap; input 1 must wait
    tbl[5]  = mk(2'b01, 2'b00, 32'hE0, 32'h0,  1'b1, 2'b01, 1'b1, 32'hE0, 1'b0);
    tbl[6]  = mk(2'b10, 2'b10, 32'h0,  32'hF1, 1'b1, 2'b01, 1'b0, 32'hE0, 1'b0);
    tbl[7]  = mk(2'b11, 2'b11, 32'hE1, 32'hF1, 1'b1, 2'b01, 1'b1, 32'hE1, 1'b1);
    tbl[8]  = mk(2'b10, 2'b10, 32'h0,  32'hF1, 1'b1, 2'b10, 1'b1, 32'hF1, 1'b1);
    // backpressure for three cycles mid-worm
    tbl[9]  = mk(2'b01, 2'b00, 32'hC0, 32'h0,  1'b1, 2'b01, 1'b1, 32'hC0, 1'b0);
    tbl[10] = mk(2'b01, 2'b01, 32'hC1, 32'h0,  1'b0, 2'b00, 1'b1, 32'hC0, 1'b0);
    tbl[11] = mk(2'b01, 2'b01, 32'hC1, 32'h0,  1'b0, 2'b00, 1'b1, 32'hC0, 1'b0);
    tbl[12] = mk(2'b01, 2'b01, 32'hC1, 32'h0,  1'b0, 2'b00, 1'b1, 32'hC0, 1'b0);
    tbl[13] = mk(2'b01, 2'b01, 32'hC1, 32'h0,  1'b1, 2'b01, 1'b1, 32'hC1, 1'b1);
    tbl[14] = mk(2'b00, 2'b00, 32'h0,  32'h0,  1'b1, 2'b00, 1'b0, 32'hC1, 1'b1);

    // reset state, with valids present to show in_ready is held low
    in_valid = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'h0);
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset out_flit", out_flit, 32'h0);
    chk("reset out_last", 32'(out_last), 32'h0);
    rst_n = 1'b0;

    for (int i = 0; i < 15; i++) step($sformatf("vec%0d", i), tbl[i]);

    // two 2-flit worms competing from reset: input 0 first, input 1 right behind
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    step("bb0", mk(2'b11, 2'b00, 32'h10, 32'h20, 1'b1, 2'b01, 1'b1, 32'h10, 1'b0));
    step("bb1", mk(2'b11, 2'b01, 32'h11, 32'h20, 1'b1, 2'b01, 1'b1, 32'h11, 1'b1));
    step("bb2", mk(2'b10, 2'b00, 32'h0,  32'h20, 1'b1, 2'b10, 1'b1, 32'h20, 1'b0));
    step("bb3", mk(2'b10, 2'b10, 32'h0,  32'h21, 1'b1, 2'b10, 1'b1, 32'h21, 1'b1));

    // fairness: continuous single-flit worms alternate starting at input 0
    for (int k = 0; k < 8; k++) begin
      step($sformatf("fair%0d", k),
           mk(2'b11, 2'b11, 32'h30 + k, 32'h40 + k, 1'b1,
              (k % 2 == 0) ? 2'b01 : 2'b10, 1'b1,
              (k % 2 == 0) ? 32'h30 + k : 32'h40 + k, 1'b1));
    end

    // reset after first flit of a 3-flit worm on input 1
    step("rw0", mk(2'b10, 2'b00, 32'h0, 32'h51, 1'b1, 2'b10, 1'b1, 32'h51, 1'b0));
    in_flit = {32'h52, 32'h0};
    #2;
    rst_n = 1'b1;
    #1;
    chk("midreset out_valid", 32'(out_valid), 32'h0);
    chk("midreset out_flit", out_flit, 32'h0);
    chk("midreset in_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    step("rw1", mk(2'b10, 2'b00, 32'h0,  32'h52, 1'b1, 2'b10, 1'b1, 32'h52, 1'b0));
    step("rw2", mk(2'b01, 2'b01, 32'h60, 32'h0,  1'b1, 2'b10, 1'b0, 32'h52, 1'b0));
    step("rw3", mk(2'b11, 2'b11, 32'h60, 32'h53, 1'b1, 2'b10, 1'b1, 32'h53, 1'b1));
    step("rw4", mk(2'b01, 2'b01, 32'h60, 32'h0,  1'b1, 2'b01, 1'b1, 32'h60, 1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
